// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared Galois-field constants and element type
package gf_pkg;

  localparam int GF_N_DEFAULT = 8;
  localparam logic [GF_N_DEFAULT:0] GF_PRIM_DEFAULT = 9'h11d;

  typedef logic [GF_N_DEFAULT-1:0] gf_elem_t;

endpackage

// File: rtl/gf_square_if.sv
// rtl/gf_square_if.sv - valid-qualified operand/result bundle for the GF squarer
interface gf_square_if
  import gf_pkg::*;
#(
  parameter int N = GF_N_DEFAULT
) ();

  logic         in_valid;
  logic [N-1:0] in;
  logic [N:0]   prim;
  logic         out_valid;
  logic [N-1:0] out;

  modport master (
    output in_valid,
    output in,
    output prim,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  in,
    input  prim,
    output out_valid,
    output out
  );

endinterface

// File: rtl/gf_reduce.sv
// rtl/gf_reduce.sv - combinational reduction of a (2N-1)-bit polynomial modulo prim
module gf_reduce
  import gf_pkg::*;
#(
  parameter int N = GF_N_DEFAULT
) (
  input  logic [2*N-2:0] a,
  input  logic [N:0]     prim,
  output logic [N-1:0]   r
);

  logic [2*N-2:0] s;
  logic           unused_prim_msb;

  // The x^N coefficient is implied by the reduction step itself.
  assign unused_prim_msb = prim[N];

  always_comb begin
    s = a;
    for (int k = 2*N-2; k >= N; k--) begin
      if (s[k]) begin
        s[k-N +: N] = s[k-N +: N] ^ prim[N-1:0];
        s[k]        = 1'b0;
      end
    end
  end

  assign r = s[N-1:0];

endmodule

// File: rtl/gf_square.sv
// rtl/gf_square.sv - registered GF(2^N) squarer; GF_SQUARE_PIPE_EN adds a second stage
module gf_square
  import gf_pkg::*;
#(
  parameter int N = GF_N_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  gf_square_if.slave bus
);

  logic [2*N-2:0] sq;
  logic [2*N-2:0] red_a;
  logic [N:0]     red_prim;
  logic           red_valid;
  logic [N-1:0]   red_r;
  logic           out_valid_q;
  logic [N-1:0]   out_q;

  // Squaring over GF(2) spreads the operand bits onto the even positions.
  always_comb begin
    sq = '0;
    for (int i = 0; i < N; i++) begin
      sq[2*i] = bus.in[i];
    end
  end

`ifdef GF_SQUARE_PIPE_EN
  logic [2*N-2:0] sq_q;
  logic [N:0]     prim_q;
  logic           valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q    <= '0;
      prim_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sq_q   <= sq;
        prim_q <= bus.prim;
      end
    end
  end

  assign red_a     = sq_q;
  assign red_prim  = prim_q;
  assign red_valid = valid_q;
`else
  assign red_a     = sq;
  assign red_prim  = bus.prim;
  assign red_valid = bus.in_valid;
`endif

  gf_reduce #(.N(N)) u_reduce (
    .a    (red_a),
    .prim (red_prim),
    .r    (red_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= red_valid;
      if (red_valid) begin
        out_q <= red_r;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_gf_square.sv
// tb/tb_gf_square.sv - randomized and directed self-checking bench for gf_square (N=8 and N=4)
module tb_gf_square;

`ifdef GF_SQUARE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gf_square_if #(.N(8)) bus8 ();
  gf_square_if #(.N(4)) bus4 ();

  gf_square #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  gf_square #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks   = 0;
  int failures = 0;

  logic       hv8 [0:2];
  logic [7:0] hd8 [0:2];
  logic       hv4 [0:2];
  logic [3:0] hd4 [0:2];
  logic [7:0] held8;
  logic [3:0] held4;
  logic [7:0] seen8 [$];
  logic [3:0] seen4 [$];

  logic [7:0] st_in  [4] = '{8'h02, 8'h10, 8'h80, 8'hff};
  logic [7:0] st_out [4] = '{8'h04, 8'h1d, 8'h13, 8'he2};

  // Reference: a*a by shift-and-add multiplication, reducing by x^n = p as the multiplicand grows.
  function automatic logic [15:0] gf_sq(logic [15:0] a, logic [16:0] p, int n);
    logic [16:0] x;
    logic [16:0] acc;
    logic [16:0] pf;
    x   = {1'b0, a};
    acc = '0;
    pf  = p | (17'd1 << n);
    for (int i = 0; i < n; i++) begin
      if (a[i]) acc = acc ^ x;
      x = x << 1;
      if (x[n]) x = x ^ pf;
    end
    return acc[15:0];
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] a8, logic [8:0] p8, logic [3:0] a4, logic [4:0] p4);
    bus8.in_valid = v;
    bus8.in       = a8;
    bus8.prim     = p8;
    bus4.in_valid = v;
    bus4.in       = a4;
    bus4.prim     = p4;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hv8[i] = 1'b0;
      hd8[i] = '0;
      hv4[i] = 1'b0;
      hd4[i] = '0;
    end
    held8 = '0;
    held4 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 2; i > 0; i--) begin
      hv8[i] = hv8[i-1];
      hd8[i] = hd8[i-1];
      hv4[i] = hv4[i-1];
      hd4[i] = hd4[i-1];
    end
    hv8[0] = bus8.in_valid;
    hd8[0] = 8'(gf_sq(16'(bus8.in), 17'(bus8.prim), 8));
    hv4[0] = bus4.in_valid;
    hd4[0] = 4'(gf_sq(16'(bus4.in), 17'(bus4.prim), 4));
    if (hv8[LAT-1]) held8 = hd8[LAT-1];
    if (hv4[LAT-1]) held4 = hd4[LAT-1];
    check("out_valid8", 16'(bus8.out_valid), 16'(hv8[LAT-1]));
    check("out8",       16'(bus8.out),       16'(held8));
    check("out_valid4", 16'(bus4.out_valid), 16'(hv4[LAT-1]));
    check("out4",       16'(bus4.out),       16'(held4));
    if (bus8.out_valid) seen8.push_back(bus8.out);
    if (bus4.out_valid) seen4.push_back(bus4.out);
  endtask

  task automatic idle_flush();
    drive(1'b0, 8'h00, 9'h11d, 4'h0, 5'h13);
    repeat (LAT) step();
  endtask

  initial begin
    logic [7:0] a8;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 9'h11d, 4'h0, 5'h13);
    clear_hist();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out8",  16'(bus8.out),       16'h0);
    check("reset_ov8",   16'(bus8.out_valid), 16'h0);
    check("reset_out4",  16'(bus4.out),       16'h0);
    check("reset_ov4",   16'(bus4.out_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse: 0x3f -> 0x3c (N=8), 0xf -> 0xa (N=4)
    seen8.delete(); seen4.delete();
    drive(1'b1, 8'h3f, 9'h11d, 4'hf, 5'h13);
    step();
    idle_flush();
    check("pulse_count8", 16'(seen8.size()), 16'd1);
    check("pulse_val8",   16'(seen8.size() > 0 ? seen8[0] : 8'hxx), 16'h3c);
    check("pulse_val4",   16'(seen4.size() > 0 ? seen4[0] : 4'hx),  16'ha);

    // Back-to-back stream
    seen8.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, st_in[i], 9'h11d, st_in[i][3:0], 5'h13);
      step();
    end
    idle_flush();
    check("stream_count", 16'(seen8.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      check("stream_val", 16'(seen8.size() > i ? seen8[i] : 8'hxx), 16'(st_out[i]));
    end

    // Zero and one, then hold
    seen8.delete();
    drive(1'b1, 8'h00, 9'h11d, 4'h0, 5'h13);
    step();
    drive(1'b1, 8'h01, 9'h11d, 4'h1, 5'h13);
    step();
    idle_flush();
    step();
    check("zero_val",  16'(seen8.size() > 0 ? seen8[0] : 8'hxx), 16'h00);
    check("one_val",   16'(seen8.size() > 1 ? seen8[1] : 8'hxx), 16'h01);
    check("hold_out",  16'(bus8.out),       16'h01);
    check("hold_ov",   16'(bus8.out_valid), 16'h0);

    // Polynomial change per beat
    seen8.delete();
    drive(1'b1, 8'h80, 9'h11d, 4'h8, 5'h13);
    step();
    drive(1'b1, 8'h80, 9'h187, 4'h8, 5'h19);
    step();
    idle_flush();
    check("poly_a", 16'(seen8.size() > 0 ? seen8[0] : 8'hxx), 16'h13);
    check("poly_b", 16'(seen8.size() > 1 ? seen8[1] : 8'hxx), 16'(gf_sq(16'h80, 17'h187, 8)));

    // Exhaustive sweeps for both polynomials; N=4 sweeps its 16 inputs alongside
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        a8 = 8'(i);
        drive(1'b1, a8, (p == 0) ? 9'h11d : 9'h187, a8[3:0], 5'h13);
        step();
      end
    end
    idle_flush();

    // Random operands, polynomials and valid gaps
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 9'($urandom), 4'($urandom), 5'($urandom));
      step();
    end

    // Asynchronous reset between edges, mid-stream
    drive(1'b1, 8'($urandom), 9'h11d, 4'($urandom), 5'h13);
    step();
    drive(1'b1, 8'($urandom), 9'h11d, 4'($urandom), 5'h13);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out8", 16'(bus8.out),       16'h0);
    check("async_ov8",  16'(bus8.out_valid), 16'h0);
    check("async_out4", 16'(bus4.out),       16'h0);
    check("async_ov4",  16'(bus4.out_valid), 16'h0);
    clear_hist();
    drive(1'b0, 8'h00, 9'h11d, 4'h0, 5'h13);
    #3;
    rst_n = 1'b1;

    seen8.delete();
    drive(1'b1, 8'h3f, 9'h11d, 4'hf, 5'h13);
    step();
    idle_flush();
    check("post_reset_count", 16'(seen8.size()), 16'd1);
    check("post_reset_val",   16'(seen8.size() > 0 ? seen8[0] : 8'hxx), 16'h3c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf_square.md
Name: gf_square

Overview:
- Registered GF(2^N) squarer: out = in^2 mod prim, with a runtime-selectable primitive polynomial.
- Used as a building block of the Galois-field arithmetic library (inversion, exponentiation, RS/BCH syndrome logic).
- Single clock domain, valid-qualified.

Parameters:
- N, 8, field degree; operands are N bits, polynomial is N+1 bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies in/prim this cycle
- in  input  N  field element, polynomial basis, bit i = coefficient of x^i
- prim  input  N+1  primitive/reduction polynomial; bit N = x^N coefficient
- out_valid  output  1  qualifies out
- out  output  N  in^2 mod prim

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: out = 0, out_valid = 0, all pipeline registers = 0, applied immediately on rst_n low; first capture on the first rising clk after rst_n deasserts.
- Square expansion: s = 2N-1 bits, s[2i] = in[i], odd bits 0 (carry-less square).
- Reduction: for k = 2N-2 down to N, if the running s[k] = 1, XOR prim[N-1:0] shifted left by (k-N) into bits k-N..k-1 and clear bit k. Result = low N bits.
- prim[N] is treated as implicitly 1 and otherwise ignored; no error is flagged when it is 0.
- prim is sampled together with in on every in_valid cycle, so the polynomial may change per operation.
- Latency: 1 cycle.
  - When in_valid = 1 at edge t, out and out_valid = 1 are visible after edge t.
  - When in_valid = 0, out_valid goes to 0 and out holds its last value.
- Throughput: one result per cycle. No backpressure; back-to-back valids produce back-to-back results.
- Zero input gives out = 0. in = 1 gives out = 1.
- Arithmetic is pure XOR. The result is always < 2^N. No overflow or sign behaviour.
- Reset asserted mid-stream discards any in-flight result; out_valid = 0 immediately.

Optional Feature:
- Macro GF_SQUARE_PIPE_EN.
- Defined: the expanded square s and prim are registered in a first stage, and reduction plus out register in a second stage.
  - Latency 2 cycles; throughput still 1 per cycle.
  - The valid bit is shifted through both stages.
  - All stage registers are reset to 0.
- Undefined: single-stage, latency 1, as described above.

Decomposition:
- Package gf_pkg:
  - GF_N_DEFAULT = 8.
  - GF_PRIM_DEFAULT = 9'h11d.
  - Function or typedef for the N-bit element type.
- Sub-module gf_reduce: purely combinational.
  - Parameter N.
  - Inputs: a (2N-1 bits) and prim (N+1 bits).
  - Output: r (N bits) = a mod prim.
  - Reusable by a future multiplier.
- gf_square contains the expansion, an instance of gf_reduce, and the valid/data registers.

Test Plan:
- N=8, prim=0x11d, in=0x3f, in_valid pulse -> out=0x3c with out_valid high 1 cycle later (2 with GF_SQUARE_PIPE_EN).
- prim=0x11d, back-to-back in = 0x02, 0x10, 0x80, 0xff -> out stream 0x04, 0x1d, 0x13, 0xe2 on consecutive cycles.
- prim=0x11d, in=0x00 then 0x01 -> 0x00 then 0x01; then in_valid low -> out_valid 0 and out held at 0x01.
- Polynomial change per beat: in=0x80 with prim=0x11d, then in=0x80 with prim=0x187 -> 0x13, then the value computed by the bench reference model for 0x187. Exhaustive sweep of all 256 inputs for both polynomials against the model.
- Reset: assert rst_n low asynchronously, mid-stream between edges -> out=0 and out_valid=0 immediately; after release, first valid input yields a correct result with nominal latency.
- N=4, prim=0x13, in=0xf -> out=0xa; sweep all 16 inputs against the model.
